// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / write-enable generation for the five-stage MIPS pipeline.
// Combines Tuse/Tnew register-dependency stalls, a multiply/divide busy
// counter and ERET-after-mtc0-EPC ordering. An exception request (Req)
// overrides every stall so the flush always proceeds.
// Optional feature macro: HAZARD_CTRL_STALL_CNT_EN adds a 32-bit stall_cnt
// output counting stalled cycles.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Req,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic [4:0] E_wa,
    input  logic [4:0] M_wa,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       D_is_md,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    input  logic       D_eret,
    input  logic       E_mtc0_epc,
    input  logic       M_mtc0_epc,
    output logic       stall,
    output logic       PC_WE,
    output logic       D_WE,
    output logic       E_WE,
    output logic       M_WE,
    output logic       W_WE,
    output logic       md_busy
`ifdef HAZARD_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       stall_eret;

    // Register-dependency, MDU and ERET stall sources plus final composition
    always_comb begin
        stall_rs   = (D_rs_addr != 5'd0) &&
                     (((D_rs_addr == E_wa) && (E_tnew > D_rs_tuse)) ||
                      ((D_rs_addr == M_wa) && (M_tnew > D_rs_tuse)));
        stall_rt   = (D_rt_addr != 5'd0) &&
                     (((D_rt_addr == E_wa) && (E_tnew > D_rt_tuse)) ||
                      ((D_rt_addr == M_wa) && (M_tnew > D_rt_tuse)));
        md_busy    = (cnt_q != 4'd0);
        stall_md   = D_is_md && (md_busy || E_md_start);
        stall_eret = D_eret && (E_mtc0_epc || M_mtc0_epc);
        // Req wins: a pending flush must never be held back by a bubble
        stall      = !Req && (stall_rs || stall_rt || stall_md || stall_eret);
        PC_WE      = !stall;
        D_WE       = !stall;
        E_WE       = 1'b1;
        M_WE       = 1'b1;
        W_WE       = 1'b1;
    end

    // MDU busy counter next state: load on an accepted start, else count down.
    // A start coinciding with Req is squashed by the flush, so it never loads;
    // Req does not abort an operation already in flight.
    always_comb begin
        cnt_d = cnt_q;
        if (E_md_start && !Req) begin
            cnt_d = E_md_is_div ? DIV_LD : MULT_LD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // MDU busy counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Stall cycle counter next state; wraps naturally, untouched by Req
    always_comb begin
        stall_cnt_d = stall ? (stall_cnt_q + 32'd1) : stall_cnt_q;
    end

    // Stall cycle counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a cycle-indexed behavioural model.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       Req;
    logic [4:0] D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_is_div, D_eret, E_mtc0_epc, M_mtc0_epc;
    logic       stall, PC_WE, D_WE, E_WE, M_WE, W_WE, md_busy;
`ifdef HAZARD_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Model state: absolute cycle index and the last cycle the MDU is busy
    int          cyc        = 0;
    int          busy_until = -1;
    logic [31:0] sc_model   = 32'd0;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .Req(Req),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .E_wa(E_wa), .M_wa(M_wa), .E_tnew(E_tnew), .M_tnew(M_tnew),
        .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .D_eret(D_eret), .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc),
        .stall(stall), .PC_WE(PC_WE), .D_WE(D_WE),
        .E_WE(E_WE), .M_WE(M_WE), .W_WE(W_WE), .md_busy(md_busy)
`ifdef HAZARD_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit exp_busy();
        return cyc <= busy_until;
    endfunction

    // A source conflicts if some producer still needs more cycles than the consumer can wait
    function automatic bit conflict(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 0) return 1'b0;
        if (a == E_wa && int'(E_tnew) > int'(tuse)) return 1'b1;
        if (a == M_wa && int'(M_tnew) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        bit any;
        if (Req) return 1'b0;
        any = conflict(D_rs_addr, D_rs_tuse) || conflict(D_rt_addr, D_rt_tuse);
        any = any || (D_is_md && (exp_busy() || E_md_start));
        any = any || (D_eret && (E_mtc0_epc || M_mtc0_epc));
        return any;
    endfunction

    // Advance one clock edge and update the model with the inputs held across it
    task automatic tick();
        bit s;
        s = exp_stall();
        @(posedge clk);
        if (!reset) begin
            busy_until = cyc;   // busy ends before the next cycle
            sc_model   = 32'd0;
        end else begin
            if (s) sc_model = sc_model + 32'd1;
            if (E_md_start && !Req)
                busy_until = cyc + (E_md_is_div ? DIV_N : MULT_N);
        end
        cyc = cyc + 1;
        #1;
    endtask

    task automatic idle_inputs();
        Req = 0; D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 3; D_rt_tuse = 3;
        E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0; D_is_md = 0;
        E_md_start = 0; E_md_is_div = 0; D_eret = 0; E_mtc0_epc = 0; M_mtc0_epc = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        tick(); tick();
        reset = 1;
        #1;
        checks++;
        if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
        checks++;
        if (stall !== 1'b0 || PC_WE !== 1'b1 || D_WE !== 1'b1)
            begin fails++; $display("FAIL reset_stall: got stall=%b PC_WE=%b D_WE=%b want 0,1,1", stall, PC_WE, D_WE); end
        checks++;
        if ({E_WE, M_WE, W_WE} !== 3'b111) begin fails++; $display("FAIL reset_we: got %b want 111", {E_WE, M_WE, W_WE}); end
`ifdef HAZARD_CTRL_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
        $display("test_reset: md_busy=%b stall=%b", md_busy, stall);
    endtask

    task automatic test_load_use();
        idle_inputs();
        E_wa = 5; E_tnew = 2; D_rs_addr = 5; D_rs_tuse = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || PC_WE !== 1'b0 || D_WE !== 1'b0)
            begin fails++; $display("FAIL load_use_stall: got stall=%b PC_WE=%b D_WE=%b want 1,0,0", stall, PC_WE, D_WE); end
        tick();
        E_tnew = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || PC_WE !== 1'b1) begin fails++; $display("FAIL load_use_release: got stall=%b PC_WE=%b want 0,1", stall, PC_WE); end
        // rt via M stage
        idle_inputs();
        M_wa = 9; M_tnew = 2; D_rt_addr = 9; D_rt_tuse = 0;
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL rt_m_stall: got %b want 1", stall); end
        $display("test_load_use: done");
        tick();
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        E_wa = 0; D_rs_addr = 0; E_tnew = 2; D_rs_tuse = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL zero_reg: got %b want 0", stall); end
        $display("test_zero_reg: stall=%b", stall);
        tick();
    endtask

    task automatic test_divide();
        idle_inputs();
        D_is_md = 1; E_md_start = 1; E_md_is_div = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL div_t_stall: got %b want 1", stall); end
        tick();
        E_md_start = 0; E_md_is_div = 0;
        for (int k = 1; k <= DIV_N; k++) begin
            #1;
            checks++;
            if (md_busy !== 1'b1 || stall !== 1'b1)
                begin fails++; $display("FAIL div_busy t+%0d: got busy=%b stall=%b want 1,1", k, md_busy, stall); end
            tick();
        end
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0)
            begin fails++; $display("FAIL div_done: got busy=%b stall=%b want 0,0", md_busy, stall); end
        $display("test_divide: released after %0d busy cycles", DIV_N);
        tick();
    endtask

    task automatic test_req_priority();
        idle_inputs();
        Req = 1; D_is_md = 1; E_md_start = 1; D_eret = 1; E_mtc0_epc = 1;
        E_wa = 3; E_tnew = 3; D_rs_addr = 3; D_rs_tuse = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || {PC_WE, D_WE, E_WE, M_WE, W_WE} !== 5'b11111)
            begin fails++; $display("FAIL req_priority: got stall=%b we=%b want 0,11111", stall, {PC_WE, D_WE, E_WE, M_WE, W_WE}); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b0) begin fails++; $display("FAIL req_no_load: got %b want 0", md_busy); end
        $display("test_req_priority: md_busy=%b", md_busy);
        tick();
    endtask

    task automatic test_eret();
        idle_inputs();
        D_eret = 1; M_mtc0_epc = 1;
        #1;
        checks++;
        if (stall !== 1'b1) begin fails++; $display("FAIL eret_stall: got %b want 1", stall); end
        tick();
        M_mtc0_epc = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin fails++; $display("FAIL eret_release: got %b want 0", stall); end
        $display("test_eret: done");
        tick();
    endtask

    task automatic test_reset_mid_mult();
        idle_inputs();
        E_md_start = 1; D_is_md = 1;
        tick();                       // count now 5
        E_md_start = 0;
        tick(); tick();               // count now 3
        #1;
        checks++;
        if (md_busy !== 1'b1) begin fails++; $display("FAIL mult_busy_pre: got %b want 1", md_busy); end
        reset = 0;
        tick();
        reset = 1;
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0)
            begin fails++; $display("FAIL reset_mid_mult: got busy=%b stall=%b want 0,0", md_busy, stall); end
`ifdef HAZARD_CTRL_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_mid_mult_cnt: got %0d want 0", stall_cnt); end
`endif
        $display("test_reset_mid_mult: md_busy=%b", md_busy);
        tick();
    endtask

    task automatic test_random();
        int nfail0;
        nfail0 = fails;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 59) != 0);
            Req         = ($urandom_range(0, 7) == 0);
            D_rs_addr   = 5'($urandom_range(0, 3));
            D_rt_addr   = 5'($urandom_range(0, 3));
            D_rs_tuse   = 2'($urandom_range(0, 3));
            D_rt_tuse   = 2'($urandom_range(0, 3));
            E_wa        = 5'($urandom_range(0, 3));
            M_wa        = 5'($urandom_range(0, 3));
            E_tnew      = 2'($urandom_range(0, 3));
            M_tnew      = 2'($urandom_range(0, 3));
            D_is_md     = ($urandom_range(0, 2) == 0);
            E_md_is_div = $urandom_range(0, 1) != 0;
            // an MDU start can only reach E while the unit is idle
            E_md_start  = !exp_busy() && ($urandom_range(0, 5) == 0);
            D_eret      = ($urandom_range(0, 3) == 0);
            E_mtc0_epc  = ($urandom_range(0, 3) == 0);
            M_mtc0_epc  = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (stall !== exp_stall() || PC_WE !== !exp_stall() || D_WE !== !exp_stall())
                begin fails++; $display("FAIL rand_stall cyc %0d: got stall=%b PC_WE=%b D_WE=%b want stall=%b", cyc, stall, PC_WE, D_WE, exp_stall()); end
            checks++;
            if (md_busy !== exp_busy())
                begin fails++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, md_busy, exp_busy()); end
            checks++;
            if ({E_WE, M_WE, W_WE} !== 3'b111)
                begin fails++; $display("FAIL rand_we cyc %0d: got %b want 111", cyc, {E_WE, M_WE, W_WE}); end
`ifdef HAZARD_CTRL_STALL_CNT_EN
            checks++;
            if (stall_cnt !== sc_model)
                begin fails++; $display("FAIL rand_stall_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt, sc_model); end
`endif
            tick();
        end
        reset = 1;
        idle_inputs();
        $display("test_random: 400 cycles, %0d new failures", fails - nfail0);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_divide();
        test_req_priority();
        test_eret();
        test_reset_mid_mult();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
